// File: rtl/cmplx_pkg.sv
// Purpose: shared types and helpers for the packed complex datapath (multiplier, accumulator, benches).
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package cmplx_pkg;

    // FSM state encoding for the frame accumulator
    typedef logic [1:0] cmplx_state_t;
    localparam cmplx_state_t ST_IDLE  = 2'd0;
    localparam cmplx_state_t ST_ACCUM = 2'd1;
    localparam cmplx_state_t ST_HOLD  = 2'd2;

    // Default packed word width and its half width (one real or imag component)
    localparam int CMPLX_N      = 16;
    localparam int CMPLX_HALF_W = CMPLX_N / 2;

    // Widest packed word the helper below can unpack
    localparam int CMPLX_EXT_W = 64;

    // Pull the real (upper=1) or imag (upper=0) half out of a packed word of
    // 2*half_w bits and sign-extend it to CMPLX_EXT_W bits. Callers truncate
    // the result to whatever width they need.
    function automatic logic [CMPLX_EXT_W-1:0] cmplx_half_sext(
        input logic [CMPLX_EXT_W-1:0] word,
        input int                     half_w,
        input logic                   upper
    );
        logic [CMPLX_EXT_W-1:0] sh;
        logic [CMPLX_EXT_W-1:0] res;
        sh  = upper ? (word >> half_w) : word;
        res = '0;
        for (int i = 0; i < CMPLX_EXT_W; i++) begin
            res[i] = (i < half_w) ? sh[i] : sh[half_w-1];
        end
        return res;
    endfunction

endpackage

// File: rtl/cmplx_acc_lane.sv
// Purpose: one signed ACC_W accumulator lane with add/load, overflow detect, optional clamp (CMPLX_ACC_SAT_EN) and clear.
// Latency: next value is combinational on 'sum'; the register updates on the clock edge of add_en.
// Backpressure: none; the parent decides when add_en is asserted.
module cmplx_acc_lane #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add_en,
    input  logic             load,
    input  logic [ACC_W:0]   sample,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   base;
    logic [ACC_W:0]   full;

    // One guard bit of headroom: the sum of two ACC_W-range values always fits
    // in ACC_W+1 bits, so overflow is just the top two bits disagreeing.
    always_comb begin
        base = load ? '0 : {acc[ACC_W-1], acc};
        full = base + sample;
        ovf  = full[ACC_W] ^ full[ACC_W-1];
`ifdef CMPLX_ACC_SAT_EN
        if (ovf) begin
            sum = full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sum = full[ACC_W-1:0];
        end
`else
        sum = full[ACC_W-1:0];
`endif
    end

    // Accumulator register: clear has priority over an add in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/cmplx_mac_accum.sv
// Purpose: accumulate LEN packed complex products {real, imag} into one complex sum per frame; CMPLX_ACC_SAT_EN selects clamping over wrap.
// Latency: out_valid rises 1 cycle after the final accept; one frame per LEN+1 cycles at best.
// Backpressure: in_ready drops while a result waits in HOLD; the result stays stable until out_ready.
module cmplx_mac_accum
    import cmplx_pkg::*;
#(
    parameter int N     = 2 * CMPLX_HALF_W,
    parameter int ACC_W = 16,
    parameter int LEN   = 8,
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*ACC_W-1:0] out_data,
    output logic               out_ovf
);

    localparam int   HALF_W  = N / 2;
    localparam logic LEN_ONE = (LEN == 1);

    generate
        if (ACC_W < HALF_W) begin : g_bad_acc_w
            $error("cmplx_mac_accum: ACC_W must be >= N/2");
        end
        if (LEN < 1) begin : g_bad_len
            $error("cmplx_mac_accum: LEN must be >= 1");
        end
    endgenerate

    cmplx_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic             last;
    logic             lane_clr;
    logic             lane_load;
    logic [ACC_W:0]   sample_r;
    logic [ACC_W:0]   sample_i;
    logic [ACC_W-1:0] sum_r;
    logic [ACC_W-1:0] sum_i;
    logic             ovf_r;
    logic             ovf_i;

    assign in_ready  = (state != ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign last      = accept && ((state == ST_IDLE) ? LEN_ONE : (cnt == CNT_W'(LEN - 1)));
    assign lane_load = (state == ST_IDLE);
    // clr is ignored in HOLD so a pending result is never lost
    assign lane_clr  = (clr && in_ready) || (last && !clr);

    assign sample_r = (ACC_W+1)'(cmplx_half_sext(CMPLX_EXT_W'(in_data), HALF_W, 1'b1));
    assign sample_i = (ACC_W+1)'(cmplx_half_sext(CMPLX_EXT_W'(in_data), HALF_W, 1'b0));

    cmplx_acc_lane #(.ACC_W(ACC_W)) u_lane_r (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (lane_clr),
        .add_en (accept),
        .load   (lane_load),
        .sample (sample_r),
        .sum    (sum_r),
        .ovf    (ovf_r)
    );

    cmplx_acc_lane #(.ACC_W(ACC_W)) u_lane_i (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (lane_clr),
        .add_en (accept),
        .load   (lane_load),
        .sample (sample_i),
        .sum    (sum_i),
        .ovf    (ovf_i)
    );

    // Frame FSM, counter, sticky overflow and the registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (state == ST_HOLD) begin
            if (out_ready) begin
                out_valid <= 1'b0;
                state     <= ST_IDLE;
            end
        end else if (clr) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            if (last) begin
                out_data  <= {sum_r, sum_i};
                out_ovf   <= ovf | ovf_r | ovf_i;
                out_valid <= 1'b1;
                cnt       <= '0;
                ovf       <= 1'b0;
                state     <= ST_HOLD;
            end else begin
                cnt   <= (state == ST_IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
                ovf   <= ovf | ovf_r | ovf_i;
                state <= ST_ACCUM;
            end
        end
    end

endmodule

// File: tb/tb_cmplx_mac_accum.sv
// Purpose: directed self-checking bench for cmplx_mac_accum (LEN=4 with ACC_W=16 and ACC_W=9 instances).
// Latency: expects out_valid visible right after the edge of the final accept.
// Backpressure: exercises HOLD with out_ready low, clr in every state, and async reset mid-frame.
module tb_cmplx_mac_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ovf;

    logic        in_ready9;
    logic        out_valid9;
    logic [17:0] out_data9;
    logic        out_ovf9;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmplx_mac_accum #(.N(16), .ACC_W(16), .LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    cmplx_mac_accum #(.N(16), .ACC_W(9), .LEN(4)) dut9 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready9),
        .in_data   (in_data),
        .out_valid (out_valid9),
        .out_ready (out_ready),
        .out_data  (out_data9),
        .out_ovf   (out_ovf9)
    );

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one word and hold it until it is accepted; returns #1 after the accepting edge
    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("send_in_ready", 36'(in_ready), 36'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 'x;
    endtask

    // Frame of four identical words, checking out_valid timing around the last one
    task automatic frame4(input string tag, input logic [15:0] d);
        send(d);
        send(d);
        send(d);
        check({tag, "_valid_pre"}, 36'(out_valid), 36'd0);
        send(d);
        check({tag, "_valid_post"}, 36'(out_valid), 36'd1);
    endtask

    // Pulse out_ready for one edge and confirm the block returns to IDLE
    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, 36'(out_valid), 36'd0);
        check({tag, "_drain_ready"}, 36'(in_ready), 36'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 'x;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 36'(out_valid), 36'd0);
        check("rst_out_data", 36'(out_data), 36'd0);
        check("rst_out_ovf", 36'(out_ovf), 36'd0);
        check("rst_in_ready", 36'(in_ready), 36'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 4 x {1, 2} -> {4, 8}
        frame4("f0102", 16'h0102);
        check("f0102_data", 36'(out_data), 36'h0_0004_0008);
        check("f0102_ovf", 36'(out_ovf), 36'd0);
        drain("f0102");

        // 4 x {-1, -128} -> {-4, -512}
        frame4("fff80", 16'hFF80);
        check("fff80_data", 36'(out_data), 36'h0_FFFC_FE00);
        check("fff80_ovf", 36'(out_ovf), 36'd0);
        drain("fff80");

        // 4 x {127, 0}: fits in 16 bits, overflows a 9-bit lane
        frame4("f7f00", 16'h7F00);
        check("f7f00_data16", 36'(out_data), 36'h0_01FC_0000);
        check("f7f00_ovf16", 36'(out_ovf), 36'd0);
`ifdef CMPLX_ACC_SAT_EN
        check("f7f00_data9", 36'(out_data9), 36'h1FE00);
`else
        check("f7f00_data9", 36'(out_data9), 36'h3F800);
`endif
        check("f7f00_ovf9", 36'(out_ovf9), 36'd1);
        drain("f7f00");

        // Backpressure: result held while out_ready stays low with input pending
        frame4("bp", 16'h0102);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 36'(in_ready), 36'd0);
            check("bp_data_stable", 36'(out_data), 36'h0_0004_0008);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = 'x;
        check("bp_valid_fall", 36'(out_valid), 36'd0);
        frame4("bp_next", 16'h0101);
        check("bp_next_data", 36'(out_data), 36'h0_0004_0004);
        check("bp_next_ovf", 36'(out_ovf), 36'd0);
        drain("bp_next");

        // clr together with a third sample: sample dropped, frame restarts
        send(16'h0101);
        send(16'h0101);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h7777;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = 'x;
        check("clr_in_ready", 36'(in_ready), 36'd1);
        check("clr_out_valid", 36'(out_valid), 36'd0);
        frame4("clr", 16'h0101);
        check("clr_data", 36'(out_data), 36'h0_0004_0004);
        check("clr_ovf", 36'(out_ovf), 36'd0);

        // clr in HOLD is ignored
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_hold_valid", 36'(out_valid), 36'd1);
        check("clr_hold_data", 36'(out_data), 36'h0_0004_0004);
        drain("clr_hold");

        // Async reset between edges mid-frame
        send(16'h0201);
        send(16'h0201);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_data", 36'(out_data), 36'd0);
        check("arst_out_valid", 36'(out_valid), 36'd0);
        check("arst_out_ovf", 36'(out_ovf), 36'd0);
        check("arst_in_ready", 36'(in_ready), 36'd1);
        check("arst_out_data9", 36'(out_data9), 36'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frame4("arst", 16'h0201);
        check("arst_data", 36'(out_data), 36'h0_0008_0004);
        check("arst_ovf", 36'(out_ovf), 36'd0);
        drain("arst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
